myo_spi_frame_master: RTL and testbench

MYO_SPI_FRAME_MASTER -- requirements
Module: myo_spi_frame_master

---
 rtl/myo_spi_pkg.sv | 32 +++
 rtl/myo_spi_clkgen.sv | 36 +++
 rtl/myo_spi_frame_master.sv | 150 +++++++++++++++
 tb/tb_myo_spi_frame_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// Shared types and constants for the myo SPI frame master: FSM states, SPI mode, CRC-16-CCITT.
package myo_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic        SPI_CPOL = 1'b0;
  localparam logic        SPI_CPHA = 1'b0;
  localparam int          WORD_W   = 16;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first CRC update over one 16-bit word.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/myo_spi_clkgen.sv
// SCK generator: toggles sck every CLK_DIV cycles while enabled, with one-cycle rise/fall strobes
// that coincide with the clock edge on which sck changes.
module myo_spi_clkgen
  import myo_spi_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt_q;
  logic       tick;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise = tick && (sck == SPI_CPOL);
  assign fall = tick && (sck != SPI_CPOL);

  // Disabling parks sck at idle level so each enable starts with a full idle half-period.
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sck   <= SPI_CPOL;
    end else if (tick) begin
      cnt_q <= '0;
      sck   <= ~sck;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/myo_spi_frame_master.sv
// SPI mode-0 frame master: sends up to MAX_WORDS 16-bit words to one of NUM_SS motor boards.
// Optional MYO_SPI_CRC_EN adds a CRC-16-CCITT check over received words (last word is the CRC).
module myo_spi_frame_master
  import myo_spi_pkg::*;
#(
  parameter int  NUM_SS    = 9,
  parameter int  CLK_DIV   = 25,
  parameter int  MAX_WORDS = 16,
  localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [15:0]       tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [15:0]       rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
`ifdef MYO_SPI_CRC_EN
  ,
  output logic              crc_error
`endif
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [LEN_W-1:0]   words_q, len_sat;
  logic               first_q;
  logic [3:0]         bit_cnt_q;
  logic [7:0]         dly_q;
  logic [WORD_W-1:0]  tx_sh_q, rx_sh_q;
  logic               rx_pend_q;
  logic               miso_s1, miso_s2;
  logic               rise, fall, smp, shf;
  logic               clk_en, start_ok, xfer, word_end, dly_done;

  assign start_ok = (state_q == ST_IDLE) && start && (frame_len != '0) && (int'(ss_sel) < NUM_SS);
  assign len_sat  = (int'(frame_len) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : frame_len;
  assign xfer     = (state_q == ST_LOAD) && tx_valid;
  assign clk_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
  assign smp      = (SPI_CPHA == 1'b0) ? rise : fall;
  assign shf      = (SPI_CPHA == 1'b0) ? fall : rise;
  assign word_end = (state_q == ST_SHIFT) && shf && (bit_cnt_q == 4'hF);
  assign dly_done = (dly_q == 8'(CLK_DIV - 1));

  assign tx_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign mosi     = tx_sh_q[WORD_W-1];

  // SETUP is the idle-low half-period before the first rising edge of a frame.
  myo_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clock (clock),
    .reset (reset),
    .en    (clk_en),
    .sck   (sck),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_LOAD;
      ST_LOAD:  if (tx_valid) state_d = first_q ? ST_SETUP : ST_SHIFT;
      ST_SETUP: if (rise)     state_d = ST_SHIFT;
      ST_SHIFT: if (word_end) state_d = (words_q == '0) ? ST_HOLD : ST_GAP;
      ST_GAP:   if (dly_done) state_d = ST_LOAD;
      ST_HOLD:  if (dly_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      words_q   <= '0;
      first_q   <= 1'b0;
      bit_cnt_q <= '0;
      dly_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_pend_q <= 1'b0;
      miso_s1   <= 1'b0;
      miso_s2   <= 1'b0;
      ss_n      <= '1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      miso_s1 <= miso;
      miso_s2 <= miso_s1;

      if (start_ok) begin
        sel_q   <= ss_sel;
        words_q <= len_sat;
        first_q <= 1'b1;
      end

      if (xfer) begin
        tx_sh_q <= tx_data;
        words_q <= words_q - LEN_W'(1);
        first_q <= 1'b0;
        if (first_q) ss_n <= ~(NUM_SS'(1) << sel_q);
      end else if (clk_en && shf) begin
        tx_sh_q <= {tx_sh_q[WORD_W-2:0], 1'b0};
      end

      if (smp) rx_sh_q <= {rx_sh_q[WORD_W-2:0], miso_s2};

      if (!clk_en)  bit_cnt_q <= '0;
      else if (shf) bit_cnt_q <= bit_cnt_q + 4'd1;

      if (((state_q == ST_GAP) || (state_q == ST_HOLD)) && !dly_done) dly_q <= dly_q + 8'd1;
      else                                                            dly_q <= '0;

      // Received word is presented one clock after the closing half-period.
      rx_pend_q <= word_end;
      rx_valid  <= rx_pend_q;
      if (rx_pend_q) rx_data <= rx_sh_q;

      if ((state_q == ST_HOLD) && dly_done) ss_n <= '1;
    end
  end

`ifdef MYO_SPI_CRC_EN
  logic [15:0] crc_q;

  // Running the CRC over the trailing CRC word leaves a zero residue on a clean frame.
  always_ff @(posedge clock) begin
    if (reset)          crc_q <= CRC_INIT;
    else if (start_ok)  crc_q <= CRC_INIT;
    else if (rx_pend_q) crc_q <= crc16_word(crc_q, rx_sh_q);
  end

  assign crc_error = (state_q == ST_DONE) && (crc_q != 16'h0000);
`endif

endmodule

// File: tb/tb_myo_spi_frame_master.sv
// Self-checking bench for myo_spi_frame_master: vector table of frames, scoreboarded MOSI/MISO words,
// plus hand sequences for stall, mid-frame reset, start-in-DONE and (with MYO_SPI_CRC_EN) CRC.
module tb_myo_spi_frame_master;

  localparam int NUM_SS    = 9;
  localparam int CLK_DIV   = 25;
  localparam int MAX_WORDS = 4;
  localparam int LIM       = 5000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ss_sel = '0;
  logic [2:0]  frame_len = '0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, busy, done, sck, mosi;
  logic        miso = 1'b0;
  logic [8:0]  ss_n;
`ifdef MYO_SPI_CRC_EN
  logic        crc_error;
  logic        crc_at_done;
`endif

  myo_spi_frame_master #(.NUM_SS(NUM_SS), .CLK_DIV(CLK_DIV), .MAX_WORDS(MAX_WORDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ss_sel    (ss_sel),
    .frame_len (frame_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .ss_n      (ss_n)
`ifdef MYO_SPI_CRC_EN
    ,
    .crc_error (crc_error)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_tx[$];
  logic [15:0] exp_rx[$];
  logic [15:0] slv_q[$];

  int cyc = 0;
  int rise_cnt = 0, rx_cnt = 0, done_cnt = 0, busy_seen = 0, multi_ss = 0, stall_bad = 0;
  logic [8:0] ss_mask = '0;
  int t_ss_fall = 0, t_rise1 = 0, t_rise2 = 0, t_last_fall = 0, t_ss_rise = 0;

  typedef struct {
    logic [3:0]       sel;
    logic [2:0]       len;
    int               nw;
    logic [3:0][15:0] tx;
    logic [3:0][15:0] rx;
    logic [8:0]       ss_exp;
    int               done_exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Bus monitor: assembles MOSI words at SCK rises, checks RX words and timing.
  initial begin
    logic        sck_p;
    logic [8:0]  ss_p;
    logic [15:0] msh;
    int          mb;
    sck_p = 1'b0; ss_p = '1; msh = '0; mb = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        mb = 0;
        sck_p = sck;
        ss_p = ss_n;
      end else begin
        if (!sck_p && sck) begin
          rise_cnt++;
          if (rise_cnt == 1) t_rise1 = cyc;
          if (rise_cnt == 2) t_rise2 = cyc;
          msh = {msh[14:0], mosi};
          mb++;
          if (mb == 16) begin
            mb = 0;
            if (exp_tx.size() > 0) chk("mosi_word", msh, exp_tx.pop_front());
            else chk("mosi_unexpected", 0, 1);
          end
        end
        if (sck_p && !sck) t_last_fall = cyc;
        if (rx_valid) begin
          rx_cnt++;
          chk("rx_latency", cyc - t_last_fall, 1);
          if (exp_rx.size() > 0) chk("rx_word", rx_data, exp_rx.pop_front());
          else chk("rx_unexpected", 0, 1);
        end
        if (done) done_cnt++;
        if (busy) busy_seen++;
        ss_mask = ss_mask | ~ss_n;
        if ($countones(~ss_n) > 1) multi_ss++;
        if (ss_p == '1 && ss_n != '1) t_ss_fall = cyc;
        if (ss_p != '1 && ss_n == '1) t_ss_rise = cyc;
        sck_p = sck;
        ss_p = ss_n;
      end
    end
  end

  // Mode-0 slave: MSB out when selected, next bit after each falling SCK, new word every 16 bits.
  initial begin
    logic        act, sck_q;
    logic [15:0] sw;
    int          sc;
    act = 1'b0; sck_q = 1'b0; sw = '0; sc = 0;
    forever begin
      @(negedge clock);
      if (reset || ss_n == '1) begin
        act = 1'b0;
      end else if (!act) begin
        act = 1'b1;
        sc = 0;
        if (slv_q.size() > 0) sw = slv_q.pop_front();
        else sw = '0;
        miso = sw[15];
      end else if (sck_q && !sck) begin
        sc++;
        if (sc == 16) begin
          sc = 0;
          if (slv_q.size() > 0) sw = slv_q.pop_front();
          else sw = '0;
        end else begin
          sw = {sw[14:0], 1'b0};
        end
        miso = sw[15];
      end
      sck_q = sck;
    end
  end

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    tx_data = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < LIM) begin
      @(negedge clock);
      n++;
    end
    chk("tx_ready_seen", tx_ready, 1);
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [3:0] sel, input logic [2:0] len, input int nw,
                          input logic [3:0][15:0] tx, input logic [3:0][15:0] rx,
                          input int stall_idx, input bit start_in_done);
    int n;
    rise_cnt = 0; rx_cnt = 0; done_cnt = 0; busy_seen = 0; multi_ss = 0; stall_bad = 0;
    ss_mask = '0;
    for (int i = 0; i < nw; i++) begin
      exp_tx.push_back(tx[i]);
      exp_rx.push_back(rx[i]);
      slv_q.push_back(rx[i]);
    end
    @(negedge clock);
    ss_sel = sel; frame_len = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (nw == 0) begin
      repeat (60) @(negedge clock);
    end else begin
      for (int i = 0; i < nw; i++) begin
        if (i == stall_idx) begin
          n = 0;
          while (!tx_ready && n < LIM) begin
            @(negedge clock);
            n++;
          end
          repeat (100) begin
            @(negedge clock);
            if (sck || ss_n == '1 || !tx_ready) stall_bad++;
          end
        end
        send_word(tx[i]);
      end
      n = 0;
      while (!done && n < LIM) begin
        @(negedge clock);
        n++;
      end
      chk("done_seen", done, 1);
`ifdef MYO_SPI_CRC_EN
      crc_at_done = crc_error;
`endif
      if (start_in_done) begin
        ss_sel = sel; frame_len = len; start = 1'b1;
      end
      @(negedge clock);
      start = 1'b0;
      if (start_in_done) chk("start_in_done_busy", busy, 0);
      repeat (3) @(negedge clock);
    end
  endtask

  initial begin
    int n;
`ifdef MYO_SPI_CRC_EN
    logic [15:0] c;
`endif
    vecs[0] = '{sel: 4'd3, len: 3'd1, nw: 1, tx: {48'h0, 16'hA5C3}, rx: {48'h0, 16'h1234},
                ss_exp: 9'h008, done_exp: 1};
    vecs[1] = '{sel: 4'd0, len: 3'd2, nw: 2, tx: {32'h0, 16'h0000, 16'hFFFF},
                rx: {32'h0, 16'h7FFE, 16'h8001}, ss_exp: 9'h001, done_exp: 1};
    vecs[2] = '{sel: 4'd8, len: 3'd1, nw: 1, tx: {48'h0, 16'h0001}, rx: {48'h0, 16'h8000},
                ss_exp: 9'h100, done_exp: 1};
    vecs[3] = '{sel: 4'd5, len: 3'd7, nw: 4, tx: {16'h8888, 16'h4444, 16'h2222, 16'h1111},
                rx: {16'hF0F0, 16'h0F0F, 16'hBEEF, 16'hCAFE}, ss_exp: 9'h020, done_exp: 1};
    vecs[4] = '{sel: 4'd9, len: 3'd1, nw: 0, tx: '0, rx: '0, ss_exp: 9'h000, done_exp: 0};
    vecs[5] = '{sel: 4'd2, len: 3'd0, nw: 0, tx: '0, rx: '0, ss_exp: 9'h000, done_exp: 0};

    repeat (4) @(negedge clock);
    chk("rst_ss_n", ss_n, 9'h1FF);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 16'h0000);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      do_frame(vecs[i].sel, vecs[i].len, vecs[i].nw, vecs[i].tx, vecs[i].rx, -1, i == 2);
      chk("done_cnt", done_cnt, vecs[i].done_exp);
      chk("rx_cnt", rx_cnt, vecs[i].nw);
      chk("sck_rises", rise_cnt, vecs[i].nw * 16);
      chk("ss_mask", ss_mask, vecs[i].ss_exp);
      chk("multi_ss", multi_ss, 0);
      chk("busy_seen", busy_seen > 0, vecs[i].nw > 0);
      chk("busy_end", busy, 0);
      chk("sb_empty", exp_tx.size() + exp_rx.size(), 0);
      if (i == 0) begin
        chk("ss_to_first_rise", t_rise1 - t_ss_fall, CLK_DIV);
        chk("sck_period", t_rise2 - t_rise1, 2 * CLK_DIV);
        chk("last_fall_to_ss_high", t_ss_rise - t_last_fall, CLK_DIV);
      end
    end

    // Producer stalls for 100 cycles before the second of three words.
    do_frame(4'd1, 3'd3, 3, {16'h0, 16'h9669, 16'h5A5A, 16'h3C3C},
             {16'h0, 16'h0506, 16'h0304, 16'h0102}, 1, 1'b0);
    chk("stall_hold", stall_bad, 0);
    chk("stall_rx_cnt", rx_cnt, 3);
    chk("stall_done_cnt", done_cnt, 1);
    chk("stall_ss_mask", ss_mask, 9'h002);

    // Reset around bit 7 of the first word, then a clean frame.
    rise_cnt = 0;
    @(negedge clock);
    ss_sel = 4'd3; frame_len = 3'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_word(16'hA5C3);
    n = 0;
    while (rise_cnt < 7 && n < LIM) begin
      @(negedge clock);
      n++;
    end
    chk("reached_bit7", rise_cnt >= 7, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_ss_n", ss_n, 9'h1FF);
    chk("midrst_sck", sck, 0);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    exp_tx.delete(); exp_rx.delete(); slv_q.delete();
    repeat (3) @(negedge clock);
    do_frame(vecs[0].sel, vecs[0].len, vecs[0].nw, vecs[0].tx, vecs[0].rx, -1, 1'b0);
    chk("post_rst_rx_cnt", rx_cnt, 1);
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_ss_mask", ss_mask, 9'h008);

`ifdef MYO_SPI_CRC_EN
    c = crc_upd(16'hFFFF, 16'h1234);
    do_frame(4'd4, 3'd2, 2, {32'h0, c, 16'h1234}, {32'h0, c, 16'h1234}, -1, 1'b0);
    chk("crc_good", crc_at_done, 0);
    do_frame(4'd4, 3'd2, 2, {32'h0, c, 16'h1234}, {32'h0, c ^ 16'h0001, 16'h1234}, -1, 1'b0);
    chk("crc_bad", crc_at_done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
